// File: rtl/morse_game_pkg.sv
// Shared definitions for the Morse number game controller.
//   game_state_e : controller FSM states
//   LFSR_POLY    : Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
//   lfsr_next    : one LFSR step
//   lfsr_digit   : folds the low nibble of the LFSR into 0..9
//   bcd_inc_sat  : two-digit BCD increment saturating at 99
//   level_time   : seconds per round for a level, never below 1
package morse_game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT   = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } game_state_e;

  // Bits 7,5,4,3 receive the feedback bit as it is shifted out of bit 0.
  localparam logic [7:0] LFSR_POLY = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    if (s[0]) begin
      return {1'b0, s[7:1]} ^ LFSR_POLY;
    end else begin
      return {1'b0, s[7:1]};
    end
  endfunction

  // Nibbles 10..15 fold onto 4..9 so every value maps to a decimal digit.
  function automatic logic [3:0] lfsr_digit(input logic [7:0] s);
    if (s[3:0] < 4'd10) begin
      return s[3:0];
    end else begin
      return s[3:0] - 4'd6;
    end
  endfunction

  function automatic logic [7:0] bcd_inc_sat(input logic [3:0] tens, input logic [3:0] ones);
    if ((tens == 4'd9) && (ones == 4'd9)) begin
      return {tens, ones};
    end else if (ones == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end else begin
      return {tens, ones + 4'd1};
    end
  endfunction

  function automatic logic [3:0] level_time(input int lvl, input int base, input int step);
    int t;
    t = base - (lvl * step);
    if (t < 1) begin
      return 4'd1;
    end else if (t > 15) begin
      return 4'd15;
    end else begin
      return t[3:0];
    end
  endfunction

endpackage

// File: rtl/morse_game_ctrl_if.sv
// Player-side and display-side signal bundle of the game controller.
//   master : difficulty selector / authentication / buttons (drives the inputs)
//   slave  : morse_game_ctrl (drives digit, timer, result and score outputs)
interface morse_game_ctrl_if #(
  parameter int LVL_W = 2
);
  logic             logged_in;
  logic [LVL_W-1:0] level;
  logic             start;
  logic             load;
  logic [3:0]       user_digit;
  logic             logout_req;
  logic [3:0]       number;
  logic             number_valid;
  logic [3:0]       secs_left;
  logic             timeout;
  logic             correct;
  logic [3:0]       score_ones;
  logic [3:0]       score_tens;
  logic [6:0]       round_idx;
  logic             game_over;
  logic             logout_done;

  modport master (
    output logged_in, level, start, load, user_digit, logout_req,
    input  number, number_valid, secs_left, timeout, correct,
           score_ones, score_tens, round_idx, game_over, logout_done
  );

  modport slave (
    input  logged_in, level, start, load, user_digit, logout_req,
    output number, number_valid, secs_left, timeout, correct,
           score_ones, score_tens, round_idx, game_over, logout_done
  );
endinterface

// File: rtl/morse_game_ctrl_round_timer.sv
// Round countdown: a prescaler dividing clk down to seconds plus a 4-bit
// seconds counter.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : zero prescaler and seconds (highest priority)
//   load       : reload prescaler, seconds <= load_secs
//   load_secs  : starting seconds for the round
//   en         : count down this cycle
//   secs_left  : registered remaining seconds
//   last_tick  : seconds==1 and the prescaler is about to wrap, i.e. an
//                enabled count this cycle ends the round
module round_timer #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_secs,
  input  logic       en,
  output logic [3:0] secs_left,
  output logic       last_tick
);
  localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic [PW-1:0] presc_r;
  logic [3:0]    secs_r;

  assign secs_left = secs_r;
  assign last_tick = (secs_r == 4'd1) && (presc_r == PRESC_ZERO);

  // Prescaler and seconds counter; counting stops once seconds reach zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= PRESC_ZERO;
      secs_r  <= 4'd0;
    end else if (clr) begin
      presc_r <= PRESC_ZERO;
      secs_r  <= 4'd0;
    end else if (load) begin
      presc_r <= PRESC_MAX;
      secs_r  <= load_secs;
    end else if (en && (secs_r != 4'd0)) begin
      if (presc_r == PRESC_ZERO) begin
        presc_r <= PRESC_MAX;
        secs_r  <= secs_r - 4'd1;
      end else begin
        presc_r <= presc_r - PRESC_ONE;
      end
    end
  end
endmodule

// File: rtl/morse_game_ctrl.sv
// Morse number game controller serving NUM_LEVELS difficulty levels.
// Presents a pseudo-random digit each round, counts down the level's time,
// checks the player's entry and keeps a saturating two-digit BCD score.
//   clk, rst : clock, synchronous active-high reset
//   bus      : morse_game_ctrl_if.slave -- logged_in/level/start/load/
//              user_digit/logout_req in; number/number_valid/secs_left/
//              timeout/correct/score_*/round_idx/game_over/logout_done out
module morse_game_ctrl
  import morse_game_pkg::*;
#(
  parameter int         NUM_LEVELS    = 3,
  parameter int         TICKS_PER_SEC = 50_000_000,
  parameter int         TIME_BASE     = 9,
  parameter int         TIME_STEP     = 2,
  parameter int         ROUNDS        = 10,
  parameter int         RESULT_TICKS  = 25_000_000,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input logic              clk,
  input logic              rst,
  morse_game_ctrl_if.slave bus
);
  localparam int            LVL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int            LVL_MAX   = NUM_LEVELS - 1;
  localparam int            RW        = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;
  localparam logic [RW-1:0] RES_MAX   = RW'(RESULT_TICKS - 1);
  localparam logic [RW-1:0] RES_ZERO  = {RW{1'b0}};
  localparam logic [RW-1:0] RES_ONE   = RW'(1);
  localparam logic [6:0]    ROUNDS_V  = 7'(ROUNDS);

  game_state_e state_r, state_nxt_s;
  logic [7:0]       lfsr_r, lfsr_nxt_s;
  logic [LVL_W-1:0] lvl_r, lvl_nxt_s, lvl_pick_s;
  logic [3:0]       number_r, number_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             timeout_r, timeout_nxt_s;
  logic             correct_r, correct_nxt_s;
  logic [3:0]       ones_r, ones_nxt_s, tens_r, tens_nxt_s;
  logic [6:0]       round_r, round_nxt_s;
  logic             over_r, over_nxt_s;
  logic             logout_done_r, logout_done_nxt_s;
  logic [RW-1:0]    rcnt_r, rcnt_nxt_s;
  logic [7:0]       score_inc_s;
  logic             clear_s;
  logic             tmr_load_s, tmr_en_s, tmr_last_s;
  logic [3:0]       tmr_secs_s, tmr_secs_load_s;

  // Logout always wins; losing authentication aborts a game silently.
  assign clear_s         = bus.logout_req || (!bus.logged_in && (state_r != IDLE));
  assign tmr_load_s      = (state_r == LOAD);
  // A submitted answer freezes the countdown in the cycle it arrives.
  assign tmr_en_s        = (state_r == WAIT) && !bus.load;
  assign tmr_secs_load_s = level_time(32'(lvl_r), TIME_BASE, TIME_STEP);
  assign score_inc_s     = bcd_inc_sat(tens_r, ones_r);

  round_timer #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (clear_s),
    .load      (tmr_load_s),
    .load_secs (tmr_secs_load_s),
    .en        (tmr_en_s),
    .secs_left (tmr_secs_s),
    .last_tick (tmr_last_s)
  );

  // Out-of-range level selections clamp to the hardest level.
  always_comb begin
    lvl_pick_s = LVL_W'(bus.level);
    if (int'(bus.level) > LVL_MAX) begin
      lvl_pick_s = LVL_W'(LVL_MAX);
    end else begin
      lvl_pick_s = LVL_W'(bus.level);
    end
  end

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_nxt_s       = state_r;
    lfsr_nxt_s        = lfsr_r;
    lvl_nxt_s         = lvl_r;
    number_nxt_s      = number_r;
    valid_nxt_s       = valid_r;
    timeout_nxt_s     = 1'b0;
    correct_nxt_s     = correct_r;
    ones_nxt_s        = ones_r;
    tens_nxt_s        = tens_r;
    round_nxt_s       = round_r;
    over_nxt_s        = over_r;
    logout_done_nxt_s = 1'b0;
    rcnt_nxt_s        = rcnt_r;

    case (state_r)
      IDLE, DONE: begin
        if (bus.start && bus.logged_in) begin
          state_nxt_s = LOAD;
          lvl_nxt_s   = lvl_pick_s;
          ones_nxt_s  = 4'd0;
          tens_nxt_s  = 4'd0;
          round_nxt_s = 7'd1;
          over_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      LOAD: begin
        lfsr_nxt_s   = lfsr_next(lfsr_r);
        number_nxt_s = lfsr_digit(lfsr_nxt_s);
        valid_nxt_s  = 1'b1;
        state_nxt_s  = WAIT;
      end
      WAIT: begin
        if (bus.load) begin
          correct_nxt_s = (bus.user_digit == number_r);
          if (bus.user_digit == number_r) begin
            {tens_nxt_s, ones_nxt_s} = score_inc_s;
          end else begin
            {tens_nxt_s, ones_nxt_s} = {tens_r, ones_r};
          end
          rcnt_nxt_s  = RES_MAX;
          state_nxt_s = RESULT;
        end else if (tmr_last_s) begin
          timeout_nxt_s = 1'b1;
          correct_nxt_s = 1'b0;
          rcnt_nxt_s    = RES_MAX;
          state_nxt_s   = RESULT;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESULT: begin
        if (rcnt_r == RES_ZERO) begin
          correct_nxt_s = 1'b0;
          if (round_r == ROUNDS_V) begin
            state_nxt_s = DONE;
            over_nxt_s  = 1'b1;
            valid_nxt_s = 1'b0;
          end else begin
            round_nxt_s = round_r + 7'd1;
            state_nxt_s = LOAD;
          end
        end else begin
          rcnt_nxt_s = rcnt_r - RES_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // Abort path overrides whatever the state logic chose this cycle.
    if (clear_s) begin
      state_nxt_s       = IDLE;
      lfsr_nxt_s        = lfsr_r;
      number_nxt_s      = 4'd0;
      valid_nxt_s       = 1'b0;
      timeout_nxt_s     = 1'b0;
      correct_nxt_s     = 1'b0;
      ones_nxt_s        = 4'd0;
      tens_nxt_s        = 4'd0;
      round_nxt_s       = 7'd0;
      over_nxt_s        = 1'b0;
      rcnt_nxt_s        = RES_ZERO;
      logout_done_nxt_s = bus.logout_req;
    end else begin
      logout_done_nxt_s = 1'b0;
    end
  end

  // State and output registers; reset also reseeds the digit generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      lfsr_r        <= LFSR_SEED;
      lvl_r         <= {LVL_W{1'b0}};
      number_r      <= 4'd0;
      valid_r       <= 1'b0;
      timeout_r     <= 1'b0;
      correct_r     <= 1'b0;
      ones_r        <= 4'd0;
      tens_r        <= 4'd0;
      round_r       <= 7'd0;
      over_r        <= 1'b0;
      logout_done_r <= 1'b0;
      rcnt_r        <= RES_ZERO;
    end else begin
      state_r       <= state_nxt_s;
      lfsr_r        <= lfsr_nxt_s;
      lvl_r         <= lvl_nxt_s;
      number_r      <= number_nxt_s;
      valid_r       <= valid_nxt_s;
      timeout_r     <= timeout_nxt_s;
      correct_r     <= correct_nxt_s;
      ones_r        <= ones_nxt_s;
      tens_r        <= tens_nxt_s;
      round_r       <= round_nxt_s;
      over_r        <= over_nxt_s;
      logout_done_r <= logout_done_nxt_s;
      rcnt_r        <= rcnt_nxt_s;
    end
  end

  assign bus.number       = number_r;
  assign bus.number_valid = valid_r;
  assign bus.secs_left    = tmr_secs_s;
  assign bus.timeout      = timeout_r;
  assign bus.correct      = correct_r;
  assign bus.score_ones   = ones_r;
  assign bus.score_tens   = tens_r;
  assign bus.round_idx    = round_r;
  assign bus.game_over    = over_r;
  assign bus.logout_done  = logout_done_r;
endmodule

// File: tb/tb_morse_game_ctrl.sv
// Directed bench for morse_game_ctrl: a 12-round instance (dut_a) for the
// main scenarios and a 99-round instance (dut_b) for the full-score game.
module tb_morse_game_ctrl;
  import morse_game_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] ma, mb;
  logic       seen;

  always #5 clk = ~clk;

  morse_game_ctrl_if #(.LVL_W(2)) bus_a ();
  morse_game_ctrl_if #(.LVL_W(2)) bus_b ();

  morse_game_ctrl #(.NUM_LEVELS(3), .TICKS_PER_SEC(4), .TIME_BASE(9), .TIME_STEP(2),
                    .ROUNDS(12), .RESULT_TICKS(2), .LFSR_SEED(8'hA5))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  morse_game_ctrl #(.NUM_LEVELS(3), .TICKS_PER_SEC(4), .TIME_BASE(9), .TIME_STEP(2),
                    .ROUNDS(99), .RESULT_TICKS(2), .LFSR_SEED(8'hA5))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Reference LFSR step written out bit by bit: x^8+x^6+x^5+x^4+1, shifting right.
  function automatic logic [7:0] mnext(input logic [7:0] s);
    return {s[0], s[7], s[6] ^ s[0], s[5] ^ s[0], s[4] ^ s[0], s[3], s[2], s[1]};
  endfunction

  function automatic logic [3:0] mdig(input logic [7:0] s);
    return (s[3:0] > 4'd9) ? (s[3:0] - 4'd6) : s[3:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.logged_in = 1'b0; bus_a.level = 2'd0; bus_a.start = 1'b0;
    bus_a.load = 1'b0; bus_a.user_digit = 4'd0; bus_a.logout_req = 1'b0;
    bus_b.logged_in = 1'b0; bus_b.level = 2'd0; bus_b.start = 1'b0;
    bus_b.load = 1'b0; bus_b.user_digit = 4'd0; bus_b.logout_req = 1'b0;
    ma = 8'hA5;
    mb = 8'hA5;
    tick(); tick();

    // Reset state
    check("rst_valid", 32'(bus_a.number_valid), 0);
    check("rst_number", 32'(bus_a.number), 0);
    check("rst_secs", 32'(bus_a.secs_left), 0);
    check("rst_round", 32'(bus_a.round_idx), 0);
    check("rst_score", 32'({bus_a.score_tens, bus_a.score_ones}), 0);
    check("rst_flags", 32'({bus_a.game_over, bus_a.correct, bus_a.timeout, bus_a.logout_done}), 0);
    rst = 1'b0;
    tick();

    // Level 0 start: LOAD after one edge, digit visible after the second
    bus_a.logged_in = 1'b1; bus_a.level = 2'd0; bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    check("load_valid", 32'(bus_a.number_valid), 0);
    check("load_round", 32'(bus_a.round_idx), 1);
    tick(); ma = mnext(ma);
    check("r1_valid", 32'(bus_a.number_valid), 1);
    check("r1_secs", 32'(bus_a.secs_left), 9);
    check("r1_first_digit", 32'(bus_a.number), 4);
    check("r1_model_digit", 32'(bus_a.number), 32'(mdig(ma)));

    // Correct answer
    bus_a.user_digit = mdig(ma); bus_a.load = 1'b1;
    tick(); bus_a.load = 1'b0;
    check("r1_correct", 32'(bus_a.correct), 1);
    check("r1_score", 32'({bus_a.score_tens, bus_a.score_ones}), 32'h01);
    check("r1_no_timeout", 32'(bus_a.timeout), 0);
    tick();
    check("r1_correct_held", 32'(bus_a.correct), 1);
    tick();
    check("r2_round", 32'(bus_a.round_idx), 2);
    check("r2_correct_clr", 32'(bus_a.correct), 0);
    tick(); ma = mnext(ma);
    check("r2_digit", 32'(bus_a.number), 32'(mdig(ma)));

    // Wrong answer leaves the score alone
    bus_a.user_digit = (mdig(ma) == 4'd9) ? 4'd0 : (mdig(ma) + 4'd1);
    bus_a.load = 1'b1;
    tick(); bus_a.load = 1'b0;
    check("r2_wrong", 32'(bus_a.correct), 0);
    check("r2_score", 32'({bus_a.score_tens, bus_a.score_ones}), 32'h01);
    tick(); tick();
    check("r3_round", 32'(bus_a.round_idx), 3);
    tick(); ma = mnext(ma);

    // logout_req beats a simultaneous correct load
    bus_a.user_digit = mdig(ma); bus_a.load = 1'b1; bus_a.logout_req = 1'b1;
    tick(); bus_a.load = 1'b0; bus_a.logout_req = 1'b0;
    check("lo_done", 32'(bus_a.logout_done), 1);
    check("lo_score", 32'({bus_a.score_tens, bus_a.score_ones}), 0);
    check("lo_round", 32'(bus_a.round_idx), 0);
    check("lo_correct", 32'(bus_a.correct), 0);
    check("lo_valid", 32'(bus_a.number_valid), 0);
    tick();
    check("lo_done_pulse", 32'(bus_a.logout_done), 0);

    // Level 2 timeout: 5 s * 4 ticks = 20 cycles after WAIT entry
    bus_a.level = 2'd2; bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    tick(); ma = mnext(ma);
    check("l2_secs", 32'(bus_a.secs_left), 5);
    check("l2_digit", 32'(bus_a.number), 32'(mdig(ma)));
    seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (bus_a.timeout) seen = 1'b1;
    end
    check("to_not_early", 32'(seen), 0);
    check("to_secs_1", 32'(bus_a.secs_left), 1);
    tick();
    check("to_pulse", 32'(bus_a.timeout), 1);
    check("to_secs_0", 32'(bus_a.secs_left), 0);
    check("to_correct", 32'(bus_a.correct), 0);
    check("to_score", 32'({bus_a.score_tens, bus_a.score_ones}), 0);
    tick();
    check("to_one_cycle", 32'(bus_a.timeout), 0);
    tick(); tick(); ma = mnext(ma);

    // load lands on the expiry cycle: load wins, no timeout
    for (int i = 0; i < 19; i++) tick();
    bus_a.user_digit = mdig(ma); bus_a.load = 1'b1;
    tick(); bus_a.load = 1'b0;
    check("lt_correct", 32'(bus_a.correct), 1);
    check("lt_no_timeout", 32'(bus_a.timeout), 0);
    check("lt_score", 32'({bus_a.score_tens, bus_a.score_ones}), 32'h01);
    check("lt_secs_frozen", 32'(bus_a.secs_left), 1);
    tick();
    check("lt_no_timeout2", 32'(bus_a.timeout), 0);
    tick(); tick(); ma = mnext(ma);

    // logged_in drop in WAIT: silent return to IDLE
    bus_a.logged_in = 1'b0;
    tick();
    check("li_round", 32'(bus_a.round_idx), 0);
    check("li_no_logout_done", 32'(bus_a.logout_done), 0);
    check("li_valid", 32'(bus_a.number_valid), 0);
    check("li_score", 32'({bus_a.score_tens, bus_a.score_ones}), 0);
    bus_a.logged_in = 1'b1;

    // Level 3 clamps to level 2
    bus_a.level = 2'd3; bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    tick(); ma = mnext(ma);
    check("clamp_secs", 32'(bus_a.secs_left), 5);

    // rst in RESULT clears everything on the next edge
    bus_a.user_digit = (mdig(ma) == 4'd9) ? 4'd0 : (mdig(ma) + 4'd1);
    bus_a.load = 1'b1;
    tick(); bus_a.load = 1'b0;
    rst = 1'b1;
    tick(); rst = 1'b0;
    ma = 8'hA5;
    check("mr_valid", 32'(bus_a.number_valid), 0);
    check("mr_number", 32'(bus_a.number), 0);
    check("mr_secs", 32'(bus_a.secs_left), 0);
    check("mr_round", 32'(bus_a.round_idx), 0);
    check("mr_flags", 32'({bus_a.game_over, bus_a.correct, bus_a.timeout, bus_a.logout_done}), 0);

    // 12-round game, every answer correct
    bus_a.level = 2'd0; bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    for (int r = 1; r <= 12; r++) begin
      tick(); ma = mnext(ma);
      check($sformatf("g12_digit_r%0d", r), 32'(bus_a.number), 32'(mdig(ma)));
      check($sformatf("g12_round_r%0d", r), 32'(bus_a.round_idx), r);
      bus_a.user_digit = mdig(ma); bus_a.load = 1'b1;
      tick(); bus_a.load = 1'b0;
      if (r == 10) check("g12_bcd_carry", 32'({bus_a.score_tens, bus_a.score_ones}), 32'h10);
      tick(); tick();
    end
    check("g12_over", 32'(bus_a.game_over), 1);
    check("g12_valid", 32'(bus_a.number_valid), 0);
    check("g12_score", 32'({bus_a.score_tens, bus_a.score_ones}), 32'h12);
    check("g12_round_end", 32'(bus_a.round_idx), 12);

    // Restart from DONE continues the LFSR sequence
    bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    check("rs_score", 32'({bus_a.score_tens, bus_a.score_ones}), 0);
    check("rs_round", 32'(bus_a.round_idx), 1);
    check("rs_over", 32'(bus_a.game_over), 0);
    tick(); ma = mnext(ma);
    check("rs_digit", 32'(bus_a.number), 32'(mdig(ma)));
    bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    check("rs_start_ignored", 32'({bus_a.number_valid, bus_a.round_idx}), 32'h81);
    bus_a.logout_req = 1'b1;
    tick(); bus_a.logout_req = 1'b0;
    check("rs_logout", 32'(bus_a.logout_done), 1);

    // 99-round game on dut_b reaches the 99 ceiling
    bus_b.logged_in = 1'b1; bus_b.start = 1'b1;
    tick(); bus_b.start = 1'b0;
    for (int r = 1; r <= 99; r++) begin
      tick(); mb = mnext(mb);
      check($sformatf("g99_digit_r%0d", r), 32'(bus_b.number), 32'(mdig(mb)));
      bus_b.user_digit = mdig(mb); bus_b.load = 1'b1;
      tick(); bus_b.load = 1'b0;
      tick(); tick();
    end
    check("g99_score", 32'({bus_b.score_tens, bus_b.score_ones}), 32'h99);
    check("g99_over", 32'(bus_b.game_over), 1);
    check("sat_fn", 32'(bcd_inc_sat(4'd9, 4'd9)), 32'h99);
    check("carry_fn", 32'(bcd_inc_sat(4'd0, 4'd9)), 32'h10);
    bus_b.start = 1'b1;
    tick(); bus_b.start = 1'b0;
    check("g99_restart_score", 32'({bus_b.score_tens, bus_b.score_ones}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
